// File: rtl/ram_frame_pingpong.sv
// rtl/ram_frame_pingpong.sv - double-buffered frame store: raster-order writes into one bank, random reads from the other.
// Optional macro RAM_OUT_REG_EN adds a register after the RAM read, so read latency becomes 2 cycles.
module ram_frame_pingpong #(
  parameter  int W      = 64,
  parameter  int H      = 64,
  parameter  int PIX_W  = 8,
  localparam int TOTAL  = W * H,
  localparam int ADDR_W = $clog2(W * H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic              wr_overflow,
  output logic              rd_frame_valid,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_data_valid,
  input  logic              rd_done
);

  localparam int                DEPTH   = 2 ** (ADDR_W + 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W:0]   TOTAL_X = (ADDR_W + 1)'(TOTAL);

  (* ram_style = "block" *) logic [PIX_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full_cnt;

  logic              wr_accept;
  logic              commit;
  logic              release_frame;
  logic              rd_fire;
  logic              rd_oob;
  logic [PIX_W-1:0]  rd_word;

  assign wr_ready       = (full_cnt < 2'd2);
  assign rd_frame_valid = (full_cnt != 2'd0);
  assign wr_accept      = wr_valid & wr_ready;
  assign commit         = wr_accept & (wr_ptr == LAST);
  assign release_frame  = rd_done & rd_frame_valid;
  assign rd_fire        = rd_en & rd_frame_valid;
  assign rd_oob         = ({1'b0, rd_addr} >= TOTAL_X);
  assign rd_word        = rd_oob ? '0 : mem[{rd_bank, rd_addr}];

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_bank, wr_ptr}] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full_cnt    <= 2'd0;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= commit ? '0 : wr_ptr + 1'b1;
      end
      if (commit) begin
        wr_bank <= ~wr_bank;
      end
      if (release_frame) begin
        rd_bank <= ~rd_bank;
      end
      // Commit and release in the same cycle cancel out.
      if (commit && !release_frame) begin
        full_cnt <= full_cnt + 2'd1;
      end else if (release_frame && !commit) begin
        full_cnt <= full_cnt - 2'd1;
      end
      if (wr_valid && !wr_ready) begin
        wr_overflow <= 1'b1;
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [PIX_W-1:0] rd_q;
  logic             rd_q_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q          <= '0;
      rd_q_valid    <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_q_valid    <= rd_fire;
      if (rd_fire) begin
        rd_q <= rd_word;
      end
      rd_data_valid <= rd_q_valid;
      if (rd_q_valid) begin
        rd_data <= rd_q;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_fire;
      if (rd_fire) begin
        rd_data <= rd_word;
      end
    end
  end
`endif

endmodule
